// File: rtl/ref_window_loader.sv
// Packs a row-major pixel stream into one WIN x WIN window for subpixel_interpolation; window valid 1 cycle after last beat.
// Backpressure: pix_ready drops while a full window waits for win_ack. Optional build macro: WIN_ZERO_ON_RESTART_EN.
// Latency: last accepted beat -> win_valid on the next edge; ack -> pix_ready on the next edge.
module ref_window_loader #(
  parameter int WIN   = 15,
  parameter int PIX_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PIX_W-1:0]         pix_in,
  input  logic                     pix_valid,
  input  logic                     pix_sof,
  output logic                     pix_ready,
  output logic [WIN*WIN*PIX_W-1:0] win_data,
  output logic                     win_valid,
  input  logic                     win_ack,
  output logic [CNT_W-1:0]         fill_cnt,
  output logic                     sync_err
);

  localparam int NPIX = WIN * WIN;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPIX - 1);

  generate
    if ((64'd1 << CNT_W) <= 64'(NPIX)) begin : g_cnt_w_check
      $error("CNT_W too narrow for WIN*WIN pixels");
    end
  endgenerate

  typedef enum logic [0:0] {ST_FILL, ST_FULL} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [CNT_W-1:0]           r_fill_cnt;
  logic                       r_sync_err;
  logic [NPIX*PIX_W-1:0]      r_win;
  logic [NPIX*PIX_W-1:0]      w_win_nxt;

  logic                       w_accept;
  logic                       w_wr_en;
  logic [CNT_W-1:0]           w_wr_idx;
  logic                       w_last;
  logic                       w_misalign;
  logic                       w_ack_hs;
  logic                       w_clear;

  assign w_accept   = (r_state == ST_FILL) && pix_valid;
  assign w_ack_hs   = (r_state == ST_FULL) && win_ack;
  // A non-sof beat with nothing written yet has no valid position and is dropped.
  assign w_wr_en    = w_accept && (pix_sof || (r_fill_cnt != '0));
  assign w_wr_idx   = pix_sof ? '0 : r_fill_cnt;
  assign w_last     = w_wr_en && (w_wr_idx == LAST_IDX);
  assign w_misalign = w_accept && (pix_sof ? (r_fill_cnt != '0) : (r_fill_cnt == '0));

`ifdef WIN_ZERO_ON_RESTART_EN
  assign w_clear = (w_accept && pix_sof) || w_ack_hs;
`else
  assign w_clear = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FILL;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: if (w_last)  w_state_nxt = ST_FULL;
      ST_FULL: if (win_ack) w_state_nxt = ST_FILL;
      default:              w_state_nxt = ST_FILL;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    pix_ready = 1'b0;
    win_valid = 1'b0;
    case (r_state)
      ST_FILL: pix_ready = 1'b1;
      ST_FULL: win_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill_cnt <= '0;
      r_sync_err <= 1'b0;
    end else begin
      if (w_misalign) r_sync_err <= 1'b1;
      if (w_ack_hs) begin
        r_fill_cnt <= '0;
      end else if (w_wr_en) begin
        r_fill_cnt <= w_wr_idx + CNT_W'(1);
      end
    end
  end

  // Optional clear happens first, then the indexed write lands on top of it.
  always_comb begin
    w_win_nxt = w_clear ? '0 : r_win;
    for (int i = 0; i < NPIX; i++) begin
      if (w_wr_en && (w_wr_idx == CNT_W'(i))) begin
        w_win_nxt[i*PIX_W +: PIX_W] = pix_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_win <= '0;
    else     r_win <= w_win_nxt;
  end

  assign win_data = r_win;
  assign fill_cnt = r_fill_cnt;
  assign sync_err = r_sync_err;

  a_fill_bound: assert property (@(posedge clk) disable iff (rst)
    r_fill_cnt <= CNT_W'(NPIX));

  a_full_hold: assert property (@(posedge clk) disable iff (rst)
    (r_state == ST_FULL && !win_ack) |=> (r_state == ST_FULL) && $stable(r_win) && $stable(r_fill_cnt));

endmodule

// File: tb/tb_ref_window_loader.sv
// Directed bench for ref_window_loader: fill, backpressure, sof faults, reset and bubbles.
module tb_ref_window_loader;
  localparam int WIN   = 15;
  localparam int PIX_W = 8;
  localparam int CNT_W = 8;
  localparam int NPIX  = WIN * WIN;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [PIX_W-1:0]        pix_in;
  logic                    pix_valid;
  logic                    pix_sof;
  logic                    pix_ready;
  logic [NPIX*PIX_W-1:0]   win_data;
  logic                    win_valid;
  logic                    win_ack;
  logic [CNT_W-1:0]        fill_cnt;
  logic                    sync_err;

  int n_checks = 0;
  int n_errs   = 0;

  ref_window_loader #(.WIN(WIN), .PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .pix_ready (pix_ready),
    .win_data  (win_data),
    .win_valid (win_valid),
    .win_ack   (win_ack),
    .fill_cnt  (fill_cnt),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic sof);
    pix_in    = d;
    pix_sof   = sof;
    pix_valid = 1'b1;
    tick();
  endtask

  task automatic idle();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic ack();
    idle();
    win_ack = 1'b1;
    tick();
    win_ack = 1'b0;
  endtask

  function automatic logic [7:0] px(input int idx);
    return win_data[PIX_W*idx +: PIX_W];
  endfunction

  logic [NPIX*PIX_W-1:0] snap;
  int bad;

  initial begin
    rst = 1'b1; pix_in = '0; pix_valid = 1'b0; pix_sof = 1'b0; win_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_eq("rst_fill_cnt", 32'(fill_cnt), 0);
    chk_eq("rst_win_valid", 32'(win_valid), 0);
    chk_eq("rst_sync_err", 32'(sync_err), 0);
    chk_eq("rst_pix_ready", 32'(pix_ready), 1);
    chk_eq("rst_win_zero", 32'(|win_data), 0);

    // Basic fill: pixel value = index
    for (int i = 0; i < NPIX; i++) begin
      beat(8'(i), i == 0);
      if (i == NPIX - 2) chk_eq("fill_not_yet_valid", 32'(win_valid), 0);
    end
    idle();
    chk_eq("fill_win_valid", 32'(win_valid), 1);
    chk_eq("fill_px0", 32'(px(0)), 32'h00);
    chk_eq("fill_px_r1c1", 32'(px(16)), 32'h10);
    chk_eq("fill_px224", 32'(px(224)), 32'hE0);
    chk_eq("fill_cnt_full", 32'(fill_cnt), 225);
    chk_eq("fill_sync_err", 32'(sync_err), 0);
    chk_eq("fill_pix_ready", 32'(pix_ready), 0);

    // Backpressure: traffic offered while the window is held
    snap = win_data;
    for (int c = 0; c < 50; c++) begin
      pix_valid = 1'b1; pix_in = 8'hFF; pix_sof = c[0];
      tick();
      chk_eq("bp_pix_ready", 32'(pix_ready), 0);
      chk_eq("bp_data_stable", 32'(win_data == snap), 1);
      chk_eq("bp_win_valid", 32'(win_valid), 1);
    end
    // Beat offered on the ack edge must not be taken
    pix_valid = 1'b1; pix_sof = 1'b1; pix_in = 8'h77; win_ack = 1'b1;
    tick();
    win_ack = 1'b0; idle();
    chk_eq("ack_win_valid", 32'(win_valid), 0);
    chk_eq("ack_fill_cnt", 32'(fill_cnt), 0);
    chk_eq("ack_pix_ready", 32'(pix_ready), 1);
    chk_eq("ack_no_write", 32'(px(0)), 32'h00);

    // Mid-fill restart at beat 100
    for (int i = 0; i < 100; i++) beat(8'(i + 1), i == 0);
    chk_eq("mid_pre_cnt", 32'(fill_cnt), 100);
    chk_eq("mid_pre_sync", 32'(sync_err), 0);
    beat(8'h55, 1'b1);
    idle();
    chk_eq("mid_cnt", 32'(fill_cnt), 1);
    chk_eq("mid_sync", 32'(sync_err), 1);
    chk_eq("mid_px0", 32'(px(0)), 32'h55);
`ifdef WIN_ZERO_ON_RESTART_EN
    chk_eq("mid_px100", 32'(px(100)), 32'h00);
    chk_eq("mid_px50", 32'(px(50)), 32'h00);
`else
    chk_eq("mid_px100", 32'(px(100)), 32'h64);
    chk_eq("mid_px50", 32'(px(50)), 32'h33);
`endif
    for (int i = 1; i < NPIX - 1; i++) beat(8'(i), 1'b0);
    idle();
    chk_eq("mid_cnt_224", 32'(fill_cnt), 224);
    chk_eq("mid_not_valid", 32'(win_valid), 0);
    beat(8'hE0, 1'b0);
    idle();
    chk_eq("mid_valid", 32'(win_valid), 1);
    chk_eq("mid_px100_final", 32'(px(100)), 32'h64);
    chk_eq("mid_px0_final", 32'(px(0)), 32'h55);
    ack();

    // Reset mid-fill, with win_ack asserted (ignored) during FILL
    win_ack = 1'b1;
    beat(8'h10, 1'b1);
    for (int i = 1; i < 120; i++) beat(8'(i), 1'b0);
    win_ack = 1'b0; idle();
    chk_eq("rmf_cnt", 32'(fill_cnt), 120);
    chk_eq("rmf_ack_ignored", 32'(win_valid), 0);
    rst = 1'b1; pix_valid = 1'b1; pix_sof = 1'b1; pix_in = 8'h99;
    tick();
    rst = 1'b0; idle();
    chk_eq("rmf_fill_cnt", 32'(fill_cnt), 0);
    chk_eq("rmf_win_valid", 32'(win_valid), 0);
    chk_eq("rmf_win_zero", 32'(|win_data), 0);
    chk_eq("rmf_sync_err", 32'(sync_err), 0);
    chk_eq("rmf_pix_ready", 32'(pix_ready), 1);

    // Missing sof: three beats dropped, then aligned fill
    for (int i = 0; i < 3; i++) begin
      beat(8'h11, 1'b0);
      chk_eq("nosof_cnt", 32'(fill_cnt), 0);
    end
    idle();
    chk_eq("nosof_sync", 32'(sync_err), 1);
    chk_eq("nosof_px0", 32'(px(0)), 32'h00);
    beat(8'hAA, 1'b1);
    idle();
    chk_eq("nosof_sof_cnt", 32'(fill_cnt), 1);
    chk_eq("nosof_sof_px0", 32'(px(0)), 32'hAA);
    for (int i = 1; i < NPIX; i++) beat(8'(i), 1'b0);
    idle();
    chk_eq("nosof_valid", 32'(win_valid), 1);
    chk_eq("nosof_px0_final", 32'(px(0)), 32'hAA);
    chk_eq("nosof_px224", 32'(px(224)), 32'hE0);
    chk_eq("nosof_cnt_full", 32'(fill_cnt), 225);
    ack();

    // Bubbles: valid every other cycle, window after 449 cycles
    for (int n = 0; n < 2 * NPIX - 1; n++) begin
      if (n % 2 == 0) begin
        beat(8'(n / 2), n == 0);
      end else begin
        idle();
        tick();
      end
      if (n == 2 * NPIX - 3) chk_eq("bub_not_valid", 32'(win_valid), 0);
    end
    idle();
    chk_eq("bub_valid_449", 32'(win_valid), 1);
    chk_eq("bub_cnt", 32'(fill_cnt), 225);
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (px(i) !== 8'(i)) bad++;
    chk_eq("bub_contents_bad_px", 32'(bad), 0);
    chk_eq("bub_px_r1c1", 32'(px(16)), 32'h10);
    ack();
    chk_eq("bub_ack_ready", 32'(pix_ready), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
